// File: rtl/axis_flow_gen.sv
// Multi-flow Ethernet test-traffic generator: round-robin flow arbitration, per-flow
// length and sequence numbers, programmable inter-frame gap, AXI-stream master output.
module axis_flow_gen #(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int N_FLOWS    = 2,
  parameter int LEN_WIDTH  = 16,
  parameter int GAP_WIDTH  = 16,
  parameter int FLOW_W     = (N_FLOWS > 1) ? $clog2(N_FLOWS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cfg_enable,
  input  logic [N_FLOWS-1:0]             cfg_flow_mask,
  input  logic [N_FLOWS*LEN_WIDTH-1:0]   cfg_frame_len,
  input  logic [GAP_WIDTH-1:0]           cfg_gap,
  input  logic [47:0]                    cfg_dst_mac,
  input  logic [47:0]                    cfg_src_mac,
  input  logic [15:0]                    cfg_ethertype,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  output logic [FLOW_W-1:0]              m_axis_tid,
  output logic                           busy,
  output logic [31:0]                    stat_frame_count,
  output logic [1:0]                     dbg_state
);

  // AXI-stream master: a beat transfers on a clock edge where tvalid && tready; once
  // tvalid rises, tdata/tkeep/tlast/tid hold until that handshake and tvalid never drops early.

  localparam int          HDR_BYTES = 20;
  localparam logic [31:0] MIN_LEN   = 32'd60;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_SEND, S_GAP} state_t;

  state_t                   state_q, state_d;
  logic [FLOW_W-1:0]        ptr_q, ptr_d, flow_q, flow_d, tid_q, tid_d;
  logic [LEN_WIDTH-1:0]     len_q, len_d;
  logic [31:0]              off_q, off_d, cnt_q, cnt_d;
  logic [GAP_WIDTH-1:0]     gap_cnt_q, gap_cnt_d;
  logic [8*HDR_BYTES-1:0]   hdr_q, hdr_d;
  logic [31:0]              seq_q [N_FLOWS];
  logic [31:0]              seq_d [N_FLOWS];
  logic [DATA_WIDTH-1:0]    tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0]    tkeep_q, tkeep_d;
  logic                     tvalid_q, tvalid_d, tlast_q, tlast_d;

  logic                     found;
  logic [FLOW_W-1:0]        sel;
  logic [N_FLOWS-1:0]       cand;
  logic [LEN_WIDTH-1:0]     len_raw, len_new, len_use;
  logic [8*HDR_BYTES-1:0]   hdr_be, hdr_new, hdr_use;
  logic [31:0]              off_use;
  logic [DATA_WIDTH-1:0]    beat_data;
  logic [KEEP_WIDTH-1:0]    beat_keep;
  logic                     beat_last;

  // Round-robin search starting at the flow after the last one served.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int i = 0; i < N_FLOWS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_FLOWS) idx = idx - N_FLOWS;
      cand = cfg_flow_mask >> idx;
      if (!found && cand[0]) begin
        found = 1'b1;
        sel   = FLOW_W'(idx);
      end
    end
  end

  // Header for the candidate frame; stored little-endian so byte i sits at [8*i +: 8].
  always_comb begin
    len_raw = cfg_frame_len[int'(sel)*LEN_WIDTH +: LEN_WIDTH];
    len_new = (32'(len_raw) < MIN_LEN) ? LEN_WIDTH'(MIN_LEN) : len_raw;
    hdr_be  = {cfg_dst_mac, cfg_src_mac[47:8], cfg_src_mac[7:0] + 8'(sel),
               cfg_ethertype, 16'(sel), seq_q[sel]};
    hdr_new = '0;
    for (int i = 0; i < HDR_BYTES; i++) begin
      hdr_new[8*i +: 8] = hdr_be[8*(HDR_BYTES-1-i) +: 8];
    end
  end

  // Beat builder: in ARB it forms the first beat from live config, otherwise from latched state.
  always_comb begin
    logic [31:0] pos;
    pos       = '0;
    hdr_use   = (state_q == S_ARB) ? hdr_new : hdr_q;
    len_use   = (state_q == S_ARB) ? len_new : len_q;
    off_use   = (state_q == S_ARB) ? 32'd0 : off_q;
    beat_data = '0;
    beat_keep = '0;
    for (int b = 0; b < KEEP_WIDTH; b++) begin
      pos = off_use + 32'(b);
      if (pos < 32'(len_use)) begin
        beat_keep[b]      = 1'b1;
        beat_data[8*b +: 8] = (pos < 32'(HDR_BYTES)) ? hdr_use[8*pos[4:0] +: 8] : pos[7:0];
      end
    end
    beat_last = (off_use + 32'(KEEP_WIDTH)) >= 32'(len_use);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    flow_d    = flow_q;
    len_d     = len_q;
    off_d     = off_q;
    cnt_d     = cnt_q;
    gap_cnt_d = gap_cnt_q;
    hdr_d     = hdr_q;
    seq_d     = seq_q;
    tdata_d   = tdata_q;
    tkeep_d   = tkeep_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tid_d     = tid_q;
    case (state_q)
      S_IDLE: if (cfg_enable && (|cfg_flow_mask)) state_d = S_ARB;
      S_ARB: begin
        if (cfg_enable && found) begin
          state_d  = S_SEND;
          flow_d   = sel;
          ptr_d    = (int'(sel) == N_FLOWS - 1) ? '0 : sel + 1'b1;
          len_d    = len_new;
          hdr_d    = hdr_new;
          off_d    = 32'(KEEP_WIDTH);
          tvalid_d = 1'b1;
          tdata_d  = beat_data;
          tkeep_d  = beat_keep;
          tlast_d  = beat_last;
          tid_d    = sel;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SEND: begin
        if (tvalid_q && m_axis_tready) begin
          if (tlast_q) begin
            tvalid_d      = 1'b0;
            tlast_d       = 1'b0;
            tdata_d       = '0;
            tkeep_d       = '0;
            cnt_d         = cnt_q + 32'd1;
            seq_d[flow_q] = seq_q[flow_q] + 32'd1;
            gap_cnt_d     = cfg_gap;
            state_d       = (cfg_gap == '0) ? S_ARB : S_GAP;
          end else begin
            tdata_d = beat_data;
            tkeep_d = beat_keep;
            tlast_d = beat_last;
            off_d   = off_q + 32'(KEEP_WIDTH);
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_WIDTH'(1)) state_d = S_ARB;
        else gap_cnt_d = gap_cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      flow_q    <= '0;
      len_q     <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
      gap_cnt_q <= '0;
      hdr_q     <= '0;
      for (int f = 0; f < N_FLOWS; f++) seq_q[f] <= '0;
      tdata_q   <= '0;
      tkeep_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tid_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      flow_q    <= flow_d;
      len_q     <= len_d;
      off_q     <= off_d;
      cnt_q     <= cnt_d;
      gap_cnt_q <= gap_cnt_d;
      hdr_q     <= hdr_d;
      for (int f = 0; f < N_FLOWS; f++) seq_q[f] <= seq_d[f];
      tdata_q   <= tdata_d;
      tkeep_q   <= tkeep_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tid_q     <= tid_d;
    end
  end

  assign m_axis_tdata     = tdata_q;
  assign m_axis_tkeep     = tkeep_q;
  assign m_axis_tvalid    = tvalid_q;
  assign m_axis_tlast     = tlast_q;
  assign m_axis_tuser     = 1'b0;
  assign m_axis_tid       = tid_q;
  assign busy             = (state_q != S_IDLE);
  assign stat_frame_count = cnt_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_axis_flow_gen.sv
// Directed bench for axis_flow_gen: a 128-bit two-flow instance plus a 64-bit instance.
module tb_axis_flow_gen;
  localparam logic [47:0] DST   = 48'h02_11_22_33_44_55;
  localparam logic [47:0] SRC   = 48'h02_AA_BB_CC_DD_FF;
  localparam logic [15:0] ETYPE = 16'h88B5;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         en = 1'b0, en64 = 1'b0, tready = 1'b1;
  logic [1:0]   mask = 2'b00, mask64 = 2'b00;
  logic [31:0]  flen = '0, flen64 = '0;
  logic [15:0]  gap = '0;
  logic [47:0]  dst = DST, src = SRC;
  logic [15:0]  etype = ETYPE;
  logic [127:0] tdata;
  logic [15:0]  tkeep;
  logic         tvalid, tlast, tuser, busy;
  logic [0:0]   tid;
  logic [31:0]  stat;
  logic [1:0]   dbg;
  logic [63:0]  d64;
  logic [7:0]   k64;
  logic         v64, l64, u64, b64;
  logic [0:0]   id64;
  logic [31:0]  s64;
  logic [1:0]   dbg64;

  int tests = 0, errors = 0, cyc = 0;
  logic [127:0] bt_data[$];
  logic [15:0]  bt_keep[$];
  logic         bt_last[$];
  logic [0:0]   bt_tid[$];
  int           bt_cyc[$];
  int           n_last = 0, stab_err = 0;
  logic [63:0]  b64_data[$];
  logic [7:0]   b64_keep[$];
  logic         b64_last[$];
  int           n64_last = 0;
  logic         stall_prev = 1'b0;
  logic [127:0] p_data;
  logic [15:0]  p_keep;
  logic         p_last;
  logic [0:0]   p_tid;

  axis_flow_gen dut (
    .clk(clk), .rst_n(rst_n), .cfg_enable(en), .cfg_flow_mask(mask), .cfg_frame_len(flen),
    .cfg_gap(gap), .cfg_dst_mac(dst), .cfg_src_mac(src), .cfg_ethertype(etype),
    .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .m_axis_tuser(tuser), .m_axis_tid(tid), .busy(busy),
    .stat_frame_count(stat), .dbg_state(dbg)
  );

  axis_flow_gen #(.DATA_WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .cfg_enable(en64), .cfg_flow_mask(mask64), .cfg_frame_len(flen64),
    .cfg_gap(gap), .cfg_dst_mac(dst), .cfg_src_mac(src), .cfg_ethertype(etype),
    .m_axis_tdata(d64), .m_axis_tkeep(k64), .m_axis_tvalid(v64), .m_axis_tready(1'b1),
    .m_axis_tlast(l64), .m_axis_tuser(u64), .m_axis_tid(id64), .busy(b64),
    .stat_frame_count(s64), .dbg_state(dbg64)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor on the falling edge: records beats that will hand off at the next rising edge
  // and flags any change of a stalled beat.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev && (tvalid !== 1'b1 || tdata !== p_data || tkeep !== p_keep ||
                         tlast !== p_last || tid !== p_tid)) stab_err++;
      stall_prev = tvalid && !tready;
      p_data = tdata; p_keep = tkeep; p_last = tlast; p_tid = tid;
      if (tvalid && tready) begin
        bt_data.push_back(tdata); bt_keep.push_back(tkeep); bt_last.push_back(tlast);
        bt_tid.push_back(tid); bt_cyc.push_back(cyc);
        if (tlast) n_last++;
      end
      if (v64) begin
        b64_data.push_back(d64); b64_keep.push_back(k64); b64_last.push_back(l64);
        if (l64) n64_last++;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic logic [7:0] exp_byte(int i, int flow, int seq);
    logic [47:0] d, s;
    logic [15:0] e, fl;
    logic [31:0] q;
    d = DST; s = SRC; e = ETYPE; fl = 16'(flow); q = 32'(seq);
    if (i < 6) return d[8*(5-i) +: 8];
    if (i == 11) return 8'(s[7:0] + 8'(flow));
    if (i < 12) return s[8*(11-i) +: 8];
    if (i == 12) return e[15:8];
    if (i == 13) return e[7:0];
    if (i == 14) return fl[15:8];
    if (i == 15) return fl[7:0];
    if (i < 20) return q[8*(19-i) +: 8];
    return 8'(i);
  endfunction

  function automatic logic [127:0] exp_data(int flow, int seq, int len, int beat, int kw);
    logic [127:0] r;
    int l;
    r = '0;
    l = (len < 60) ? 60 : len;
    for (int b = 0; b < kw; b++)
      if (beat*kw + b < l) r[8*b +: 8] = exp_byte(beat*kw + b, flow, seq);
    return r;
  endfunction

  function automatic logic [15:0] exp_keep(int len, int beat, int kw);
    logic [15:0] r;
    int l;
    r = '0;
    l = (len < 60) ? 60 : len;
    for (int b = 0; b < kw; b++) if (beat*kw + b < l) r[b] = 1'b1;
    return r;
  endfunction

  // driver tasks
  task automatic clear_mon();
    bt_data.delete(); bt_keep.delete(); bt_last.delete(); bt_tid.delete(); bt_cyc.delete();
    b64_data.delete(); b64_keep.delete(); b64_last.delete();
    n_last = 0; n64_last = 0; stab_err = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; en = 1'b0; en64 = 1'b0; tready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_mon();
  endtask

  task automatic wait_lasts(int n, bit rnd, string name);
    int k;
    k = 0;
    while (n_last < n && k < 3000) begin
      @(posedge clk); #1;
      if (rnd) tready = 1'($urandom_range(0, 1));
      k++;
    end
    tests++;
    if (n_last < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d frames, need %0d", name, n_last, n);
    end
  endtask

  task automatic stop_gen(string name);
    int k;
    @(posedge clk); #1;
    en = 1'b0; en64 = 1'b0; tready = 1'b1;
    k = 0;
    while ((busy || b64) && k < 300) begin @(posedge clk); #1; k++; end
    tests++;
    if (busy || b64) begin errors++; $display("FAIL %s_stop: busy still high", name); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    tests++; if (tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", tvalid); end
    tests++; if (tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %h want 0", tdata); end
    tests++; if (tkeep !== '0) begin errors++; $display("FAIL rst_tkeep: got %h want 0", tkeep); end
    tests++; if (tid !== '0 || tlast !== 1'b0 || tuser !== 1'b0) begin
      errors++; $display("FAIL rst_tid_tlast: got %b/%b/%b want 0/0/0", tid, tlast, tuser); end
    tests++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    tests++; if (stat !== 32'd0) begin errors++; $display("FAIL rst_stat: got %0d want 0", stat); end
    tests++; if (v64 !== 1'b0 || d64 !== '0) begin errors++; $display("FAIL rst_64: got %b/%h want 0/0", v64, d64); end
    do_reset();
    @(negedge clk);
    tests++; if (tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_release_idle: got tvalid %b busy %b want 0/0", tvalid, busy); end
  endtask

  task automatic test_round_robin();
    do_reset();
    mask = 2'b11; flen = {16'd64, 16'd64}; gap = 16'd0; en = 1'b1;
    wait_lasts(4, 1'b0, "rr");
    stop_gen("rr");
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 4; b++) begin
        int j;
        j = f*4 + b;
        if (j >= bt_data.size()) break;
        tests++; if (bt_tid[j] !== 1'(f % 2)) begin errors++; $display("FAIL rr_tid f%0d b%0d: got %0d want %0d", f, b, bt_tid[j], f % 2); end
        tests++; if (bt_data[j] !== exp_data(f % 2, f / 2, 64, b, 16)) begin
          errors++; $display("FAIL rr_data f%0d b%0d: got %h want %h", f, b, bt_data[j], exp_data(f % 2, f / 2, 64, b, 16)); end
        tests++; if (bt_keep[j] !== 16'hFFFF) begin errors++; $display("FAIL rr_keep f%0d b%0d: got %h want ffff", f, b, bt_keep[j]); end
        tests++; if (bt_last[j] !== (b == 3)) begin errors++; $display("FAIL rr_last f%0d b%0d: got %b want %b", f, b, bt_last[j], b == 3); end
        if (b > 0) begin
          tests++; if (bt_cyc[j] - bt_cyc[j-1] !== 1) begin
            errors++; $display("FAIL rr_b2b f%0d b%0d: got spacing %0d want 1", f, b, bt_cyc[j] - bt_cyc[j-1]); end
        end else if (f > 0) begin
          tests++; if (bt_cyc[j] - bt_cyc[j-1] - 1 !== 1) begin
            errors++; $display("FAIL rr_idle f%0d: got %0d idle want 1", f, bt_cyc[j] - bt_cyc[j-1] - 1); end
        end
      end
    end
    if (bt_data.size() >= 16) begin
      tests++; if (bt_data[4][95:88] !== 8'h00) begin errors++; $display("FAIL rr_src_byte11_flow1: got %h want 00", bt_data[4][95:88]); end
      tests++; if (bt_data[0][111:96] !== 16'hB588) begin errors++; $display("FAIL rr_ethertype: got %h want b588", bt_data[0][111:96]); end
      tests++; if (bt_data[13][31:0] !== 32'h0100_0000) begin errors++; $display("FAIL rr_seq_f3: got %h want 01000000", bt_data[13][31:0]); end
    end
    tests++; if (stat !== 32'(n_last)) begin errors++; $display("FAIL rr_stat: got %0d want %0d", stat, n_last); end
  endtask

  task automatic test_lengths();
    do_reset();
    mask = 2'b01; flen = {16'd0, 16'd65}; gap = 16'd2; en = 1'b1;
    wait_lasts(2, 1'b0, "len65");
    stop_gen("len65");
    if (bt_data.size() >= 6) begin
      tests++; if (bt_last[3] !== 1'b0 || bt_last[4] !== 1'b1) begin
        errors++; $display("FAIL len65_last: got %b%b want 01", bt_last[3], bt_last[4]); end
      tests++; if (bt_keep[4] !== 16'h0001) begin errors++; $display("FAIL len65_keep: got %h want 0001", bt_keep[4]); end
      tests++; if (bt_data[4] !== 128'h40) begin errors++; $display("FAIL len65_data: got %h want 40", bt_data[4]); end
      tests++; if (bt_data[1] !== exp_data(0, 0, 65, 1, 16)) begin
        errors++; $display("FAIL len65_beat1: got %h want %h", bt_data[1], exp_data(0, 0, 65, 1, 16)); end
      tests++; if (bt_data[5] !== exp_data(0, 1, 65, 0, 16)) begin
        errors++; $display("FAIL len65_f1: got %h want %h", bt_data[5], exp_data(0, 1, 65, 0, 16)); end
      tests++; if (bt_cyc[5] - bt_cyc[4] - 1 !== 3) begin
        errors++; $display("FAIL len65_gap2: got %0d idle want 3", bt_cyc[5] - bt_cyc[4] - 1); end
    end
    do_reset();
    flen = {16'd0, 16'd30}; en = 1'b1;
    wait_lasts(1, 1'b0, "len30");
    stop_gen("len30");
    if (bt_data.size() >= 4) begin
      tests++; if (bt_last[2] !== 1'b0 || bt_last[3] !== 1'b1) begin
        errors++; $display("FAIL len30_last: got %b%b want 01", bt_last[2], bt_last[3]); end
      tests++; if (bt_keep[3] !== 16'h0FFF) begin errors++; $display("FAIL len30_keep: got %h want 0fff", bt_keep[3]); end
      tests++; if (bt_data[3] !== 128'h0000_0000_3B3A_3938_3736_3534_3332_3130) begin
        errors++; $display("FAIL len30_data: got %h want 3b3a..30", bt_data[3]); end
    end
  endtask

  task automatic test_width64();
    int k;
    do_reset();
    mask64 = 2'b01; flen64 = {16'd0, 16'd64}; gap = 16'd0; en64 = 1'b1;
    k = 0;
    while (n64_last < 1 && k < 200) begin @(posedge clk); #1; k++; end
    tests++; if (n64_last < 1) begin errors++; $display("FAIL w64_timeout: got %0d frames want 1", n64_last); end
    stop_gen("w64");
    if (b64_data.size() >= 8) begin
      tests++; if (b64_last[6] !== 1'b0 || b64_last[7] !== 1'b1) begin
        errors++; $display("FAIL w64_beats: tlast at 6/7 got %b%b want 01", b64_last[6], b64_last[7]); end
      tests++; if (b64_keep[7] !== 8'hFF || b64_keep[0] !== 8'hFF) begin
        errors++; $display("FAIL w64_keep: got %h/%h want ff/ff", b64_keep[0], b64_keep[7]); end
      tests++; if (b64_data[0] !== 64'hAA02_5544_3322_1102) begin
        errors++; $display("FAIL w64_beat0: got %h want aa02554433221102", b64_data[0]); end
      tests++; if (b64_data[7] !== 64'h3F3E_3D3C_3B3A_3938) begin
        errors++; $display("FAIL w64_beat7: got %h want 3f3e3d3c3b3a3938", b64_data[7]); end
    end
    tests++; if (s64 !== 32'(n64_last)) begin errors++; $display("FAIL w64_stat: got %0d want %0d", s64, n64_last); end
  endtask

  task automatic test_backpressure();
    int j;
    do_reset();
    mask = 2'b11; flen = {16'd64, 16'd70}; gap = 16'd1; en = 1'b1;
    wait_lasts(4, 1'b1, "bp");
    stop_gen("bp");
    j = 0;
    for (int f = 0; f < 4; f++) begin
      int nb, ln;
      ln = (f % 2 == 0) ? 70 : 64;
      nb = (f % 2 == 0) ? 5 : 4;
      for (int b = 0; b < nb; b++) begin
        if (j >= bt_data.size()) break;
        tests++; if (bt_data[j] !== exp_data(f % 2, f / 2, ln, b, 16) || bt_tid[j] !== 1'(f % 2)) begin
          errors++; $display("FAIL bp_data f%0d b%0d: got %h/%0d want %h/%0d", f, b, bt_data[j], bt_tid[j], exp_data(f % 2, f / 2, ln, b, 16), f % 2); end
        tests++; if (bt_keep[j] !== exp_keep(ln, b, 16) || bt_last[j] !== (b == nb - 1)) begin
          errors++; $display("FAIL bp_keep f%0d b%0d: got %h/%b want %h/%b", f, b, bt_keep[j], bt_last[j], exp_keep(ln, b, 16), b == nb - 1); end
        j++;
      end
    end
    tests++; if (stab_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_err); end
  endtask

  task automatic test_gap();
    do_reset();
    mask = 2'b10; flen = {16'd64, 16'd64}; gap = 16'd10; en = 1'b1;
    wait_lasts(2, 1'b0, "gap");
    stop_gen("gap");
    for (int j = 0; j < 8 && j < bt_data.size(); j++) begin
      tests++; if (bt_tid[j] !== 1'b1 || bt_data[j] !== exp_data(1, j / 4, 64, j % 4, 16)) begin
        errors++; $display("FAIL gap_flow1 b%0d: got %0d/%h want 1/%h", j, bt_tid[j], bt_data[j], exp_data(1, j / 4, 64, j % 4, 16)); end
    end
    if (bt_data.size() >= 5) begin
      tests++; if (bt_cyc[4] - bt_cyc[3] - 1 !== 11) begin
        errors++; $display("FAIL gap_idle: got %0d idle want 11", bt_cyc[4] - bt_cyc[3] - 1); end
    end
  endtask

  task automatic test_enable_drop();
    int k, fall;
    do_reset();
    mask = 2'b01; flen = {16'd0, 16'd64}; gap = 16'd3; en = 1'b1;
    k = 0;
    while (bt_data.size() < 2 && k < 200) begin @(posedge clk); #1; k++; end
    en = 1'b0;
    k = 0; fall = -1;
    while (k < 200) begin
      @(negedge clk);
      if (!busy) begin fall = cyc; break; end
      k++;
    end
    repeat (20) @(posedge clk);
    #1;
    tests++; if (n_last !== 1 || bt_data.size() !== 4) begin
      errors++; $display("FAIL drop_frames: got %0d frames %0d beats want 1/4", n_last, bt_data.size()); end
    if (bt_data.size() == 4) begin
      tests++; if (bt_last[3] !== 1'b1) begin errors++; $display("FAIL drop_tlast: got %b want 1", bt_last[3]); end
      tests++; if (fall - bt_cyc[3] !== 5) begin
        errors++; $display("FAIL drop_busy_fall: got %0d cycles want 5", fall - bt_cyc[3]); end
    end
    tests++; if (stat !== 32'd1) begin errors++; $display("FAIL drop_stat: got %0d want 1", stat); end
    tests++; if (tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL drop_idle: got tvalid %b busy %b want 0/0", tvalid, busy); end
  endtask

  task automatic test_reset_mid();
    int k;
    do_reset();
    mask = 2'b11; flen = {16'd64, 16'd64}; gap = 16'd0; en = 1'b1;
    k = 0;
    while (bt_data.size() < 6 && k < 200) begin @(posedge clk); #1; k++; end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (tvalid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_async: got tvalid %b busy %b want 0/0", tvalid, busy); end
    tests++; if (stat !== 32'd0 || tkeep !== '0 || tid !== '0) begin
      errors++; $display("FAIL mid_clear: got stat %0d keep %h tid %0d want 0/0/0", stat, tkeep, tid); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    clear_mon();
    wait_lasts(1, 1'b0, "mid");
    stop_gen("mid");
    if (bt_data.size() >= 2) begin
      tests++; if (bt_tid[0] !== 1'b0) begin errors++; $display("FAIL mid_tid: got %0d want 0", bt_tid[0]); end
      tests++; if (bt_data[1] !== exp_data(0, 0, 64, 1, 16)) begin
        errors++; $display("FAIL mid_seq: got %h want %h", bt_data[1], exp_data(0, 0, 64, 1, 16)); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lengths();
    test_width64();
    test_backpressure();
    test_gap();
    test_enable_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
